// File: rtl/gcd_controller_if.sv
// gcd_controller_if: groups the controller's requester handshake, datapath
// compare flags and datapath control lines into one bundle.
//   master : requester + datapath side (drives start/in_valid/flags)
//   slave  : the controller (drives ready, loads, selects and status)
//
// Handshake: an operand transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on controller state, never on
// in_valid, so the requester may wait for in_ready before raising in_valid.
interface gcd_controller_if #(
   parameter int ITER_W = 16
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic              gt;
   logic              lt;
   logic              eq;
   logic              ldA;
   logic              ldB;
   logic              sel1;
   logic              sel2;
   logic              sel_in;
   logic              busy;
   logic              done;
   logic              err;
   logic [ITER_W-1:0] iter_count;

   modport master (
      output start, in_valid, gt, lt, eq,
      input  in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
   );

   modport slave (
      input  start, in_valid, gt, lt, eq,
      output in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
   );
endinterface

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the 16-bit subtractive GCD datapath.
// Loads operand A then B over a valid/ready handshake, then steers one
// subtraction per clock from the gt/lt/eq flags until A == B, and pulses done.
// Optional feature macro: GCD_CTRL_TIMEOUT_EN adds an iteration watchdog
// (MAX_ITER) with an ERR state and a sticky err flag. Without it, err is 0.
module gcd_controller #(
   parameter int ITER_W = 16
`ifdef GCD_CTRL_TIMEOUT_EN
   ,
   parameter int MAX_ITER = 65535
`endif
) (
   input  logic             clk,
   input  logic             rst,
   gcd_controller_if.slave  ctrl_bus,
   output logic [2:0]       o_dbg_state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LD_A = 3'd1;
   localparam logic [2:0] S_LD_B = 3'd2;
   localparam logic [2:0] S_CALC = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
`ifdef GCD_CTRL_TIMEOUT_EN
   localparam logic [2:0] S_ERR  = 3'd5;
   localparam logic [ITER_W-1:0] W_MAX_ITER = ITER_W'(MAX_ITER);
`endif

   localparam logic [ITER_W-1:0] ITER_SAT = '1;

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic [ITER_W-1:0] r_iter;
   logic              w_step;
   logic              w_in_ready;
   logic              w_ldA;
   logic              w_ldB;
   logic              w_sel1;
   logic              w_sel2;
   logic              w_sel_in;
   logic              w_done;
   logic              w_start_accept;

   assign w_start_accept = (r_state == S_IDLE) && ctrl_bus.start;

   // Next-state and Mealy control decode; every output defaults to 0.
   always_comb begin
      w_next_state = r_state;
      w_step       = 1'b0;
      w_in_ready   = 1'b0;
      w_ldA        = 1'b0;
      w_ldB        = 1'b0;
      w_sel1       = 1'b0;
      w_sel2       = 1'b0;
      w_sel_in     = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ctrl_bus.start) begin
               w_next_state = S_LD_A;
            end
         end
         S_LD_A: begin
            w_in_ready = 1'b1;
            w_sel_in   = 1'b1;
            w_ldA      = ctrl_bus.in_valid;
            if (ctrl_bus.in_valid) begin
               w_next_state = S_LD_B;
            end
         end
         S_LD_B: begin
            w_in_ready = 1'b1;
            w_sel_in   = 1'b1;
            w_ldB      = ctrl_bus.in_valid;
            if (ctrl_bus.in_valid) begin
               w_next_state = S_CALC;
            end
         end
         S_CALC: begin
            if (ctrl_bus.eq) begin
               w_next_state = S_DONE;
            end
`ifdef GCD_CTRL_TIMEOUT_EN
            else if (r_iter == W_MAX_ITER) begin
               // Not converging (e.g. a zero operand): abort without a load.
               w_next_state = S_ERR;
            end
`endif
            else if (ctrl_bus.gt) begin
               w_ldA  = 1'b1;
               w_sel1 = 1'b1;
               w_step = 1'b1;
            end else if (ctrl_bus.lt) begin
               w_ldB  = 1'b1;
               w_sel2 = 1'b1;
               w_step = 1'b1;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
`ifdef GCD_CTRL_TIMEOUT_EN
         S_ERR: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
`endif
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register and saturating subtraction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start_accept) begin
            r_iter <= '0;
         end else if (w_step && (r_iter != ITER_SAT)) begin
            r_iter <= r_iter + ITER_W'(1);
         end
      end
   end

`ifdef GCD_CTRL_TIMEOUT_EN
   logic r_err;

   // Sticky abort flag: set on entry to ERR, cleared by the next accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_start_accept) begin
         r_err <= 1'b0;
      end else if ((r_state == S_CALC) && (w_next_state == S_ERR)) begin
         r_err <= 1'b1;
      end
   end

   assign ctrl_bus.err = r_err;
`else
   assign ctrl_bus.err = 1'b0;
`endif

   assign ctrl_bus.in_ready   = w_in_ready;
   assign ctrl_bus.ldA        = w_ldA;
   assign ctrl_bus.ldB        = w_ldB;
   assign ctrl_bus.sel1       = w_sel1;
   assign ctrl_bus.sel2       = w_sel2;
   assign ctrl_bus.sel_in     = w_sel_in;
   assign ctrl_bus.busy       = (r_state != S_IDLE);
   assign ctrl_bus.done       = w_done;
   assign ctrl_bus.iter_count = r_iter;
   assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: drives gcd_controller against a behavioural subtractive
// GCD datapath and checks results, latencies and handshake behaviour against
// a reference computed with plain arithmetic. Two instances: a 16-bit counter
// build, and a 4-bit counter build for saturation (or, with
// GCD_CTRL_TIMEOUT_EN, the watchdog with MAX_ITER=8).
module tb_gcd_controller;

   localparam int RUN_BOUND = 70000;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   gcd_controller_if #(.ITER_W(16)) bus  ();
   gcd_controller_if #(.ITER_W(4))  bus2 ();

   logic [2:0] dbg1;
   logic [2:0] dbg2;

   gcd_controller #(.ITER_W(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl_bus    (bus),
      .o_dbg_state (dbg1)
   );

   gcd_controller #(
      .ITER_W(4)
`ifdef GCD_CTRL_TIMEOUT_EN
      ,
      .MAX_ITER(8)
`endif
   ) u_dut4 (
      .clk         (clk),
      .rst         (rst),
      .ctrl_bus    (bus2),
      .o_dbg_state (dbg2)
   );

   // Behavioural datapaths: registers A/B, compare flags, subtract muxes.
   logic [15:0] dp_a, dp_b, dp_in;
   logic [15:0] dp2_a, dp2_b, dp2_in;

   assign bus.gt  = dp_a > dp_b;
   assign bus.lt  = dp_a < dp_b;
   assign bus.eq  = dp_a == dp_b;
   assign bus2.gt = dp2_a > dp2_b;
   assign bus2.lt = dp2_a < dp2_b;
   assign bus2.eq = dp2_a == dp2_b;

   wire [15:0] sub1 = bus.sel1  ? dp_a - dp_b   : (bus.sel2  ? dp_b - dp_a   : 16'd0);
   wire [15:0] sub2 = bus2.sel1 ? dp2_a - dp2_b : (bus2.sel2 ? dp2_b - dp2_a : 16'd0);

   always @(posedge clk) begin
      if (bus.ldA)  dp_a  <= bus.sel_in  ? dp_in  : sub1;
      if (bus.ldB)  dp_b  <= bus.sel_in  ? dp_in  : sub1;
      if (bus2.ldA) dp2_a <= bus2.sel_in ? dp2_in : sub2;
      if (bus2.ldB) dp2_b <= bus2.sel_in ? dp2_in : sub2;
   end

   wire [8:0] ctl1 = {bus.in_ready, bus.ldA, bus.ldB, bus.sel1, bus.sel2,
                      bus.sel_in, bus.busy, bus.done, bus.err};
   wire [8:0] ctl2 = {bus2.in_ready, bus2.ldA, bus2.ldB, bus2.sel1, bus2.sel2,
                      bus2.sel_in, bus2.busy, bus2.done, bus2.err};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: plain subtractive Euclid on integers.
   function automatic int ref_gcd(input int a, input int b);
      while (a != b) begin
         if (a > b) a = a - b;
         else       b = b - a;
      end
      return a;
   endfunction

   function automatic int ref_steps(input int a, input int b);
      int n;
      n = 0;
      while (a != b) begin
         if (a > b) a = a - b;
         else       b = b - a;
         n++;
      end
      return n;
   endfunction

   // Driver for instance 1. Cycle 0 is the cycle start is presented in IDLE.
   task automatic drive_run(input logic [15:0] a, input logic [15:0] b,
                            input int sa, input int sb, input bit poke,
                            output int done_cyc, output int rdy_cyc,
                            output int both_ld, output logic [15:0] res_a,
                            output logic [15:0] res_iter, output logic res_err,
                            output int busy_after);
      int cyc, phase, calc_cyc, la, lb;
      la = sa; lb = sb; phase = 0; calc_cyc = 0; cyc = 0;
      done_cyc = -1; rdy_cyc = 0; both_ld = 0; busy_after = 0;
      res_a = '0; res_iter = '0; res_err = 1'b0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.in_valid = 1'b0;
      while (done_cyc < 0 && cyc < RUN_BOUND) begin
         @(negedge clk);
         cyc++;
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         if (phase == 2) begin
            calc_cyc++;
            if (poke && calc_cyc == 1) bus.start = 1'b1;
         end
         if (bus.in_ready) begin
            rdy_cyc++;
            if (phase == 0) begin
               if (la > 0) la--;
               else begin bus.in_valid = 1'b1; dp_in = a; phase = 1; end
            end else if (phase == 1) begin
               if (lb > 0) lb--;
               else begin bus.in_valid = 1'b1; dp_in = b; phase = 2; end
            end
         end
         #1;
         if (bus.ldA && bus.ldB) both_ld++;
         if (bus.done) begin
            done_cyc = cyc;
            res_a    = dp_a;
            res_iter = bus.iter_count;
            res_err  = bus.err;
         end
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (bus.busy) busy_after++;
      end
   endtask

   // Driver for instance 2 (no stalls).
   task automatic drive_run2(input logic [15:0] a, input logic [15:0] b,
                             output int done_cyc, output logic [15:0] res_a,
                             output logic [3:0] res_iter, output logic res_err);
      int cyc, phase;
      cyc = 0; phase = 0; done_cyc = -1;
      res_a = '0; res_iter = '0; res_err = 1'b0;
      @(negedge clk);
      bus2.start    = 1'b1;
      bus2.in_valid = 1'b0;
      while (done_cyc < 0 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         bus2.start    = 1'b0;
         bus2.in_valid = 1'b0;
         if (bus2.in_ready && phase < 2) begin
            bus2.in_valid = 1'b1;
            dp2_in        = (phase == 0) ? a : b;
            phase++;
         end
         #1;
         if (bus2.done) begin
            done_cyc = cyc;
            res_a    = dp2_a;
            res_iter = bus2.iter_count;
            res_err  = bus2.err;
         end
      end
      bus2.start    = 1'b0;
      bus2.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (ctl1 !== 9'd0) begin
         failures++;
         $display("FAIL reset_ctl1 got=%b exp=%b", ctl1, 9'd0);
      end
      checks++;
      if (bus.iter_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_iter1 got=%0d exp=0", bus.iter_count);
      end
      checks++;
      if (ctl2 !== 9'd0) begin
         failures++;
         $display("FAIL reset_ctl2 got=%b exp=%b", ctl2, 9'd0);
      end
      checks++;
      if (bus2.iter_count !== 4'd0) begin
         failures++;
         $display("FAIL reset_iter2 got=%0d exp=0", bus2.iter_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int a_tab[3] = '{48, 7, 65535};
      int b_tab[3] = '{18, 7, 1};
      for (int i = 0; i < 3; i++) begin
         int dc, rc, bl, ba, n, g;
         logic [15:0] ra, ri;
         logic re;
         n = ref_steps(a_tab[i], b_tab[i]);
         g = ref_gcd(a_tab[i], b_tab[i]);
         drive_run(16'(a_tab[i]), 16'(b_tab[i]), 0, 0, 1'b0, dc, rc, bl, ra, ri, re, ba);
         checks++;
         if (dc != 4 + n) begin
            failures++;
            $display("FAIL basic_done_cycle[%0d] got=%0d exp=%0d", i, dc, 4 + n);
         end
         checks++;
         if (ra !== 16'(g)) begin
            failures++;
            $display("FAIL basic_result[%0d] got=%0d exp=%0d", i, ra, g);
         end
         checks++;
         if (ri !== 16'(n)) begin
            failures++;
            $display("FAIL basic_iter[%0d] got=%0d exp=%0d", i, ri, n);
         end
         checks++;
         if (re !== 1'b0) begin
            failures++;
            $display("FAIL basic_err[%0d] got=%b exp=0", i, re);
         end
         checks++;
         if (bl != 0 || rc != 2) begin
            failures++;
            $display("FAIL basic_handshake[%0d] both_ld=%0d rdy=%0d exp 0/2", i, bl, rc);
         end
         checks++;
         if (ba != 0) begin
            failures++;
            $display("FAIL basic_busy_after[%0d] got=%0d exp=0", i, ba);
         end
      end
   endtask

   task automatic test_stall_and_ignored_start();
      int dc, rc, bl, ba, n;
      logic [15:0] ra, ri;
      logic re;
      n = ref_steps(9, 6);
      drive_run(16'd9, 16'd6, 3, 2, 1'b1, dc, rc, bl, ra, ri, re, ba);
      checks++;
      if (dc != 4 + n + 5) begin
         failures++;
         $display("FAIL stall_done_cycle got=%0d exp=%0d", dc, 4 + n + 5);
      end
      checks++;
      if (ra !== 16'd3) begin
         failures++;
         $display("FAIL stall_result got=%0d exp=3", ra);
      end
      checks++;
      if (rc != 7) begin
         failures++;
         $display("FAIL stall_in_ready_cycles got=%0d exp=7", rc);
      end
      checks++;
      if (ba != 0) begin
         failures++;
         $display("FAIL ignored_start busy_after got=%0d exp=0", ba);
      end
      checks++;
      if (ri !== 16'(n)) begin
         failures++;
         $display("FAIL stall_iter got=%0d exp=%0d", ri, n);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         int a, b, sa, sb, dc, rc, bl, ba, n, g;
         logic [15:0] ra, ri;
         logic re;
         a  = int'($urandom_range(200, 1));
         b  = int'($urandom_range(200, 1));
         sa = int'($urandom_range(2, 0));
         sb = int'($urandom_range(2, 0));
         n  = ref_steps(a, b);
         g  = ref_gcd(a, b);
         drive_run(16'(a), 16'(b), sa, sb, 1'b0, dc, rc, bl, ra, ri, re, ba);
         checks++;
         if (dc != 4 + n + sa + sb) begin
            failures++;
            $display("FAIL rand_done_cycle a=%0d b=%0d got=%0d exp=%0d", a, b, dc, 4 + n + sa + sb);
         end
         checks++;
         if (ra !== 16'(g) || ri !== 16'(n)) begin
            failures++;
            $display("FAIL rand_result a=%0d b=%0d got=%0d/%0d exp=%0d/%0d", a, b, ra, ri, g, n);
         end
         checks++;
         if (bl != 0 || rc != 2 + sa + sb) begin
            failures++;
            $display("FAIL rand_handshake both_ld=%0d rdy=%0d exp 0/%0d", bl, rc, 2 + sa + sb);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int dc, rc, bl, ba;
      logic [15:0] ra, ri;
      logic re;
      @(negedge clk);
      bus.start = 1'b1;                          // cycle 0
      @(negedge clk);
      bus.start = 1'b0; bus.in_valid = 1'b1; dp_in = 16'd48;   // cycle 1
      @(negedge clk);
      dp_in = 16'd18;                            // cycle 2
      @(negedge clk);
      bus.in_valid = 1'b0;                       // cycle 3, first CALC
      @(negedge clk);
      rst = 1'b1;                                // cycle 4, second CALC
      #1;
      checks++;
      if (bus.iter_count !== 16'd1 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL midrun_before_rst iter=%0d busy=%b exp 1/1", bus.iter_count, bus.busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if (ctl1 !== 9'd0 || bus.iter_count !== 16'd0) begin
         failures++;
         $display("FAIL midrun_after_rst ctl=%b iter=%0d exp all zero", ctl1, bus.iter_count);
      end
      rst = 1'b0;
      drive_run(16'd48, 16'd18, 0, 0, 1'b0, dc, rc, bl, ra, ri, re, ba);
      checks++;
      if (ra !== 16'd6 || dc != 8) begin
         failures++;
         $display("FAIL midrun_fresh_run result=%0d cycle=%0d exp 6/8", ra, dc);
      end
   endtask

`ifdef GCD_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      int dc;
      logic [15:0] ra;
      logic [3:0] ri;
      logic re;
      drive_run2(16'd5, 16'd0, dc, ra, ri, re);
      checks++;
      if (dc != 12 || re !== 1'b1) begin
         failures++;
         $display("FAIL timeout_abort cycle=%0d err=%b exp 12/1", dc, re);
      end
      checks++;
      if (ri !== 4'd8) begin
         failures++;
         $display("FAIL timeout_iter got=%0d exp=8", ri);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus2.err !== 1'b1 || bus2.busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_sticky err=%b busy=%b exp 1/0", bus2.err, bus2.busy);
      end
      drive_run2(16'd12, 16'd8, dc, ra, ri, re);
      checks++;
      if (ra !== 16'd4 || re !== 1'b0 || dc != 4 + ref_steps(12, 8)) begin
         failures++;
         $display("FAIL timeout_recover result=%0d err=%b cycle=%0d exp 4/0/%0d", ra, re, dc, 4 + ref_steps(12, 8));
      end
   endtask
`else
   task automatic test_saturation();
      int dc, n;
      logic [15:0] ra;
      logic [3:0] ri;
      logic re;
      n = ref_steps(20, 1);
      drive_run2(16'd20, 16'd1, dc, ra, ri, re);
      checks++;
      if (ri !== 4'd15) begin
         failures++;
         $display("FAIL sat_iter got=%0d exp=15", ri);
      end
      checks++;
      if (ra !== 16'd1 || dc != 4 + n || re !== 1'b0) begin
         failures++;
         $display("FAIL sat_run result=%0d cycle=%0d err=%b exp 1/%0d/0", ra, dc, re, 4 + n);
      end
   endtask
`endif

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus2.start    = 1'b0;
      bus2.in_valid = 1'b0;
      dp_in         = '0;
      dp2_in        = '0;
      test_reset();
      test_basic();
      test_stall_and_ignored_start();
      test_back_to_back();
      test_reset_mid_run();
`ifdef GCD_CTRL_TIMEOUT_EN
      test_timeout();
`else
      test_saturation();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM for the 16-bit subtractive GCD datapath. It sequences operand loading over a valid/ready input handshake, then drives the datapath's register-load and mux-select lines from its `gt`/`lt`/`eq` flags until the two registers match. It reports completion with a one-cycle `done` pulse; the result is then held in datapath register A. It sits between the system-level requester and `GCD_datapath`, with one control output per datapath control input.

## Interface
- `ITER_W`, 16: width of the subtraction iteration counter.
- `MAX_ITER`, 65535: subtraction count at which the watchdog aborts. Used only with `GCD_CTRL_TIMEOUT_EN`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new GCD; sampled only in IDLE.
- `in_valid`  in  1  requester drives an operand on datapath `data_in`.
- `in_ready`  out  1  controller accepts an operand this cycle.
- `gt`, `lt`, `eq`  in  1 each  datapath compare flags (A>B, A<B, A==B).
- `ldA`, `ldB`  out  1 each  datapath register load enables.
- `sel1`, `sel2`, `sel_in`  out  1 each  datapath mux selects (1 selects the first mux input).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  watchdog abort flag; sticky until the next accepted `start`.
- `iter_count`  out  ITER_W  number of subtractions performed in the current or last run.

## Operation
- States: IDLE, LD_A, LD_B, CALC, DONE; ERR exists only with the macro.
- IDLE:
  - All datapath controls are 0.
  - `start`=1 → LD_A. On this transition, `iter_count` and `err` clear.
- LD_A:
  - `in_ready`=1, `sel_in`=1, `sel1`=`sel2`=0.
  - `ldA` = `in_valid` (combinational).
  - On `in_valid` → LD_B; otherwise stay (stall, no timeout).
- LD_B: same as LD_A, but drives `ldB` and transitions → CALC.
- CALC (Mealy on the flags, `sel_in`=0):
  - `eq` → DONE, no load.
  - `gt` → `ldA`=1, `sel1`=1, `sel2`=0 (A ← A−B). Stay in CALC; `iter_count`+1.
  - `lt` → `ldB`=1, `sel1`=0, `sel2`=1 (B ← B−A). Stay in CALC; `iter_count`+1.
  - Flags are trusted to be one-hot. If none is set, hold all controls at 0 and stay.
- DONE: `done`=1 for one cycle → IDLE. A and B both hold the GCD.
- `start` outside IDLE is ignored; it is not queued.
- `iter_count` saturates at all-ones and never wraps.
- `rst` at any point:
  - Next edge returns to IDLE.
  - `busy`/`done`/`err`/`in_ready`/`ldA`/`ldB`/selects = 0; `iter_count` = 0.
  - Datapath registers are not cleared, and their contents are undefined until reloaded.
- Reset values: every output is 0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE:
  - cycle 1: LD_A
  - cycle 2: LD_B (if `in_valid` has no gaps)
  - cycles 3..3+N: CALC (N subtractions plus the `eq` cycle)
  - cycle 4+N: `done`
- Each load stall cycle adds one cycle.
- One subtraction per clock. The datapath flags settle combinationally from the registers loaded at the previous edge.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `in_ready` is high for exactly the LD_A and LD_B cycles. An operand transfers when `in_valid` && `in_ready` at the rising edge.
- The controller never asserts `ldA` and `ldB` in the same cycle.

## Configuration
- `GCD_CTRL_TIMEOUT_EN` defined: watchdog is active.
  - In CALC, if `iter_count` == `MAX_ITER` and `eq`=0 → ERR, with no load that cycle.
  - ERR lasts one cycle: `done`=1, `err` set, → IDLE.
  - This catches a zero operand (A−0 never converges).
- Not defined:
  - No ERR state and no compare logic; `err` is tied to 0.
  - A zero operand hangs in CALC until `rst`. Requesters must not issue zero operands.

## Test plan
- A=48, B=18, no stalls:
  - 4 subtractions (30, 12, B=6, A=6).
  - `done` at cycle 8, A=6, `iter_count`=4, `err`=0.
- A=7, B=7:
  - 0 subtractions; `done` at cycle 4, A=7, `iter_count`=0.
- A=65535, B=1:
  - 65534 subtractions, A=1, `done` at cycle 65538.
  - Also check `iter_count` saturation with `ITER_W`=4: it reads 15.
- `in_valid` low for 3 cycles in LD_A and 2 cycles in LD_B, with A=9, B=6:
  - `in_ready` held high through the stalls; result 3.
  - `done` delayed by exactly 5 cycles.
  - A `start` pulse during CALC is ignored.
- With `GCD_CTRL_TIMEOUT_EN`, `MAX_ITER`=8, A=5, B=0:
  - After 8 subtractions: `done`=1 and `err`=1 in the same cycle.
  - `err` holds until the next `start`; the next run (12, 8) → 4 with `err`=0.
- `rst` asserted at the 2nd CALC cycle of a 48/18 run:
  - All outputs 0 the next cycle.
  - A fresh run (48, 18) completes with 6.
